// File: rtl/uart_result_tx.sv
// uart_result_tx: sends an inference class index over a UART line as one
// ASCII digit ('0'..'9', or 'E' for indices 10..15), optionally followed by
// CR LF. Each byte is framed with a start bit, 8 data bits (LSB first) and
// STOP_BITS stop bits. The line, busy, ready and frame_done are registered.
module uart_result_tx #(
    parameter int CLKS_PER_BIT = 27,
    parameter int STOP_BITS    = 1,
    parameter int SEND_CRLF    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       result_valid,
    input  logic [3:0] result,
    output logic       result_ready,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int               BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    // Stop counter runs 0..STOP_BITS-1 (STOP_BITS is 1 or 2).
    localparam logic              STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic [1:0]        BYTE_LAST = (SEND_CRLF != 0) ? 2'd2 : 2'd0;

    // Byte of the message at position idx for class index res.
    function automatic logic [7:0] msg_byte(input logic [1:0] idx, input logic [3:0] res);
        logic [7:0] b;
        case (idx)
            2'd0:    b = (res < 4'd10) ? (8'h30 + {4'h0, res}) : 8'h45;
            2'd1:    b = 8'h0D;
            2'd2:    b = 8'h0A;
            default: b = 8'hFF;
        endcase
        return b;
    endfunction

    state_t            r_state;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit;
    logic              r_stop;
    logic [1:0]        r_byte;
    logic [3:0]        r_result;
    logic              r_tx;
    logic              r_busy;
    logic              r_ready;
    logic              r_frame_done;

    state_t            w_state_nxt;
    logic [BAUD_W-1:0] w_baud_nxt;
    logic [2:0]        w_bit_nxt;
    logic              w_stop_nxt;
    logic [1:0]        w_byte_nxt;
    logic              w_accept;
    logic              w_bit_end;
    logic [7:0]        w_data_byte;
    logic              w_tx_nxt;

    assign tx           = r_tx;
    assign busy         = r_busy;
    assign result_ready = r_ready;
    assign frame_done   = r_frame_done;

    // Next-state and counter logic; output values are derived from the next state
    // so the registered outputs line up with the state they describe.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_stop_nxt  = r_stop;
        w_byte_nxt  = r_byte;
        w_accept    = result_valid & r_ready;
        w_bit_end   = (r_baud == BAUD_LAST);

        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    w_state_nxt = S_START;
                    w_baud_nxt  = '0;
                    w_bit_nxt   = 3'd0;
                    w_stop_nxt  = 1'b0;
                    w_byte_nxt  = 2'd0;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_baud_nxt  = '0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                    w_baud_nxt  = '0;
                    w_bit_nxt   = 3'd0;
                end else begin
                    w_baud_nxt  = r_baud + BAUD_ONE;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_baud_nxt = '0;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = S_STOP;
                        w_bit_nxt   = 3'd0;
                        w_stop_nxt  = 1'b0;
                    end else begin
                        w_bit_nxt   = r_bit + 3'd1;
                    end
                end else begin
                    w_baud_nxt = r_baud + BAUD_ONE;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_baud_nxt = '0;
                    if (r_stop == STOP_LAST) begin
                        w_stop_nxt = 1'b0;
                        if (r_byte == BYTE_LAST) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_state_nxt = S_START;
                            w_byte_nxt  = r_byte + 2'd1;
                        end
                    end else begin
                        w_stop_nxt = 1'b1;
                    end
                end else begin
                    w_baud_nxt = r_baud + BAUD_ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_baud_nxt  = '0;
                w_bit_nxt   = 3'd0;
                w_stop_nxt  = 1'b0;
                w_byte_nxt  = 2'd0;
            end
        endcase

        w_data_byte = msg_byte(w_byte_nxt, r_result);
        case (w_state_nxt)
            S_START: w_tx_nxt = 1'b0;
            S_DATA:  w_tx_nxt = w_data_byte[w_bit_nxt];
            default: w_tx_nxt = 1'b1;
        endcase
    end

    // State, counters, captured result and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_baud       <= '0;
            r_bit        <= 3'd0;
            r_stop       <= 1'b0;
            r_byte       <= 2'd0;
            r_result     <= 4'd0;
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_ready      <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_baud       <= w_baud_nxt;
            r_bit        <= w_bit_nxt;
            r_stop       <= w_stop_nxt;
            r_byte       <= w_byte_nxt;
            r_tx         <= w_tx_nxt;
            r_busy       <= (w_state_nxt == S_START) || (w_state_nxt == S_DATA) ||
                            (w_state_nxt == S_STOP);
            r_ready      <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_DONE);
            r_frame_done <= (w_state_nxt == S_DONE);
            if (w_accept) begin
                r_result <= result;
            end else begin
                r_result <= r_result;
            end
        end
    end

endmodule

// File: doc/uart_result_tx.md
UART_RESULT_TX -- requirements
Module: uart_result_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 27, meaning clk cycles per UART bit (3.125 MHz / 115200 baud).
REQ-002 The block SHALL have parameter STOP_BITS, default 1, meaning number of stop bits per byte (legal values 1 or 2).
REQ-003 The block SHALL have parameter SEND_CRLF, default 1, meaning append CR (0x0D) and LF (0x0A) after the digit byte when 1.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port result_valid, input, 1 bit: classification result available (driven from the inference engine's done).
REQ-007 The block SHALL have port result, input, 4 bits: class index from the inference engine.
REQ-008 The block SHALL have port result_ready, output, 1 bit: block can accept a new result.
REQ-009 The block SHALL have port tx, output, 1 bit: UART serial line, idle high.
REQ-010 The block SHALL have port busy, output, 1 bit: a message is in transmission.
REQ-011 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse when the last bit of the message ends.

Function
REQ-012 A result SHALL be accepted on the rising edge where result_valid=1 and result_ready=1; result is captured in that same edge.
REQ-013 After acceptance, result_ready SHALL be 0 and busy SHALL be 1 until frame_done.
REQ-014 While result_ready=0, result_valid and result SHALL be ignored; no queuing.
REQ-015 Byte 0 SHALL be 0x30+result for result 0..9, and 0x45 ('E') for result 10..15.
REQ-016 With SEND_CRLF=1 the message SHALL be byte 0, 0x0D, 0x0A; with SEND_CRLF=0 it SHALL be byte 0 only.
REQ-017 Each byte SHALL be framed 8N1-style: one start bit (0), 8 data bits LSB first, STOP_BITS stop bits (1), with no parity.
REQ-018 Each bit SHALL be held on tx for exactly CLKS_PER_BIT clk cycles, using a baud counter that reloads at every bit boundary.
REQ-019 The start bit SHALL appear on tx in the first cycle after the acceptance edge.
REQ-020 Consecutive bytes SHALL be back-to-back, with the next start bit immediately following the last stop-bit cycle and no idle gap.
REQ-021 The FSM SHALL have states IDLE -> START -> DATA (bit index 0..7) -> STOP (count 1..STOP_BITS) -> START for the next byte when bytes remain, else DONE.
REQ-022 DONE SHALL last one cycle, asserting frame_done=1, result_ready=1 and busy=0, then return to IDLE; tx SHALL be 1 in DONE.
REQ-023 A new result with valid=1 during the DONE cycle SHALL be accepted (ready=1 there), and its start bit SHALL follow in the next cycle.
REQ-024 Message length SHALL be bytes*(9+STOP_BITS)*CLKS_PER_BIT cycles from the first start-bit cycle to the end of the last stop bit, where bytes is 3 or 1.
REQ-025 The byte index SHALL be a 2-bit counter that never exceeds the message length; the bit index SHALL be a 3-bit counter that wraps 7->0 only on transition to STOP.
REQ-026 tx SHALL be driven from a register, so there are no combinational glitches.

Reset
REQ-027 While rst_n=0, the block SHALL immediately set tx=1, busy=0, result_ready=1, frame_done=0, FSM=IDLE, and clear all counters.
REQ-028 Reset asserted mid-message SHALL abort it, with tx returning high asynchronously; no partial byte resumes after release.
REQ-029 After rst_n deasserts, a result SHALL be acceptable on the first rising edge.

Verification
REQ-030 Verification SHALL cover: result=7, SEND_CRLF=1, CLKS_PER_BIT=27 -> tx sends 0x37, 0x0D, 0x0A LSB-first; frame_done pulses once, exactly 810 cycles after the first start-bit cycle.
REQ-031 Verification SHALL cover: result=12 -> first byte is 0x45; result=0 -> first byte is 0x30.
REQ-032 Verification SHALL cover: result_valid held high with changing result during a transmission -> only the first captured value is sent; a second message starts right after the DONE cycle with the value present then.
REQ-033 Verification SHALL cover: rst_n pulsed low during the data bits of byte 1 -> tx=1 immediately, busy=0, ready=1; a following result=3 sends a clean 0x33 message.
REQ-034 Verification SHALL cover: STOP_BITS=2, SEND_CRLF=0, CLKS_PER_BIT=4 -> single byte, 44 cycles long, ending with 8 high cycles, then frame_done.
REQ-035 Verification SHALL cover: a loopback into the uart_receiver at matching baud -> rx_msg equals the sent bytes in order.
